// File: rtl/ann_leaf_search_if.sv
// ----------------------------------------------------------------------------
// ann_leaf_search_if
// Handshake and result bus of the ANN leaf-search engine.
//
// Signals:
//   fsm_start         1-cycle start request (driven by the controller side)
//   busy              engine is scanning (READ/WAIT/SELECT/DONE)
//   fsm_done          1-cycle pulse once all queries have been reported
//   result_valid      1-cycle pulse per query result
//   result_query_idx  query/leaf index of the reported result
//   result_patch_idx  nearest patch within the leaf
//   result_dist       squared L2 distance of the nearest patch
//   result_patch_idx2 runner-up patch      (only with SECOND_BEST_EN)
//   result_dist2      runner-up distance   (only with SECOND_BEST_EN)
//
// Modports:
//   master - controller / testbench side (drives fsm_start)
//   slave  - engine side (drives status and results)
// ----------------------------------------------------------------------------
interface ann_leaf_search_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int PIDX_WIDTH = 3,
    parameter int DIST_WIDTH = 26
);
    logic                  fsm_start;
    logic                  busy;
    logic                  fsm_done;
    logic                  result_valid;
    logic [ADDR_WIDTH-1:0] result_query_idx;
    logic [PIDX_WIDTH-1:0] result_patch_idx;
    logic [DIST_WIDTH-1:0] result_dist;
`ifdef SECOND_BEST_EN
    logic [PIDX_WIDTH-1:0] result_patch_idx2;
    logic [DIST_WIDTH-1:0] result_dist2;
`endif

    modport master (
        output fsm_start,
        input  busy,
        input  fsm_done,
        input  result_valid,
        input  result_query_idx,
        input  result_patch_idx,
`ifdef SECOND_BEST_EN
        input  result_patch_idx2,
        input  result_dist2,
`endif
        input  result_dist
    );

    modport slave (
        input  fsm_start,
        output busy,
        output fsm_done,
        output result_valid,
        output result_query_idx,
        output result_patch_idx,
`ifdef SECOND_BEST_EN
        output result_patch_idx2,
        output result_dist2,
`endif
        output result_dist
    );
endinterface

// File: rtl/ann_leaf_search_top.sv
// ----------------------------------------------------------------------------
// ann_leaf_search_top
// Patch-match ANN datapath: for every query q (0..NUM_LEAVES-1) the engine
// exhaustively searches kd-tree leaf q (LEAF_SIZE patches) and reports the
// patch with the smallest squared L2 distance to the query.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset (memories are not reset)
//   bus    ann_leaf_search_if.slave: fsm_start / busy / fsm_done and the
//          result_* bus (see the interface file)
//
// Memories (contents loaded externally, never reset):
//   leaf_mem_inst.loop_ram_patch_gen[i].ram_patch_inst.mem  patch i of each leaf
//   query_mem_inst.mem                                      one query per word
// Word packing: element k lives at [k*DATA_WIDTH +: DATA_WIDTH].
//
// Optional feature: define SECOND_BEST_EN to also report the runner-up patch
// and its distance on result_patch_idx2 / result_dist2.
// ----------------------------------------------------------------------------

// Single-port-read RAM with a 1-cycle registered read and a write port used
// only for loading.
module ann_ram #(
    parameter int WIDTH = 55,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Load path
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Synchronous read, data available the cycle after the address
    always_ff @(posedge clk) begin
        r_rdata <= mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// LEAF_SIZE banks sharing one address; bank i holds patch i of every leaf.
module ann_leaf_mem #(
    parameter int WIDTH     = 55,
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int LEAF_SIZE = 8
) (
    input  logic                             clk,
    input  logic [AW-1:0]                    i_addr,
    output logic [LEAF_SIZE-1:0][WIDTH-1:0]  o_rdata
);
    for (genvar i = 0; i < LEAF_SIZE; i++) begin : loop_ram_patch_gen
        ann_ram #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) ram_patch_inst (
            .clk     (clk),
            .i_we    (1'b0),
            .i_waddr ({AW{1'b0}}),
            .i_wdata ({WIDTH{1'b0}}),
            .i_raddr (i_addr),
            .o_rdata (o_rdata[i])
        );
    end
endmodule

module ann_leaf_search_top #(
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_LEAVES = 64,
    parameter int ADDR_WIDTH = $clog2(NUM_LEAVES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ann_leaf_search_if.slave     bus
);
    localparam int W      = PATCH_SIZE * DATA_WIDTH;
    localparam int PIDX_W = $clog2(LEAF_SIZE);
    localparam int DIST_W = 2 * DATA_WIDTH + $clog2(PATCH_SIZE) + 1;
    localparam int SQ_W   = 2 * DATA_WIDTH + 2;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(NUM_LEAVES - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SELECT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Squared L2 distance between two packed patches. Differences are taken
    // one bit wider than the elements so -1024 - 1023 cannot wrap; the sum
    // is full width and never saturates.
    function automatic logic [DIST_W-1:0] sq_dist(input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [DATA_WIDTH-1:0]      ea;
        logic [DATA_WIDTH-1:0]      eb;
        logic signed [DATA_WIDTH:0] d;
        logic signed [SQ_W-1:0]     dx;
        logic [SQ_W-1:0]            sq;
        logic [DIST_W-1:0]          acc;
        acc = {DIST_W{1'b0}};
        for (int k = 0; k < PATCH_SIZE; k++) begin
            ea  = a[k*DATA_WIDTH +: DATA_WIDTH];
            eb  = b[k*DATA_WIDTH +: DATA_WIDTH];
            d   = $signed({ea[DATA_WIDTH-1], ea}) - $signed({eb[DATA_WIDTH-1], eb});
            dx  = {{(DATA_WIDTH+1){d[DATA_WIDTH]}}, d};
            sq  = $unsigned(dx * dx);
            acc = acc + {{(DIST_W-SQ_W){1'b0}}, sq};
        end
        return acc;
    endfunction

    state_t                          r_state;
    logic [ADDR_WIDTH-1:0]           r_cnt;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_valid;
    logic [ADDR_WIDTH-1:0]           r_res_qidx;
    logic [PIDX_W-1:0]               r_res_pidx;
    logic [DIST_W-1:0]               r_res_dist;
    logic [LEAF_SIZE-1:0][DIST_W-1:0] r_leaf_dist;

    logic [LEAF_SIZE-1:0][W-1:0]     w_leaf_word;
    logic [W-1:0]                    w_query_word;
    logic [DIST_W-1:0]               w_best_dist;
    logic [PIDX_W-1:0]               w_best_idx;
`ifdef SECOND_BEST_EN
    logic [PIDX_W-1:0]               r_res_pidx2;
    logic [DIST_W-1:0]               r_res_dist2;
    logic [DIST_W-1:0]               w_sec_dist;
    logic [PIDX_W-1:0]               w_sec_idx;
`endif

    // All banks and the query RAM are addressed by the query counter; the
    // counter is stable from READ through SELECT of each query.
    ann_leaf_mem #(
        .WIDTH     (W),
        .DEPTH     (NUM_LEAVES),
        .AW        (ADDR_WIDTH),
        .LEAF_SIZE (LEAF_SIZE)
    ) leaf_mem_inst (
        .clk     (clk),
        .i_addr  (r_cnt),
        .o_rdata (w_leaf_word)
    );

    ann_ram #(
        .WIDTH (W),
        .DEPTH (NUM_LEAVES),
        .AW    (ADDR_WIDTH)
    ) query_mem_inst (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr ({ADDR_WIDTH{1'b0}}),
        .i_wdata ({W{1'b0}}),
        .i_raddr (r_cnt),
        .o_rdata (w_query_word)
    );

    // Distance stage: capture all LEAF_SIZE distances while RAM data is valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_leaf_dist <= '0;
        end else if (r_state == ST_WAIT) begin
            for (int i = 0; i < LEAF_SIZE; i++) begin
                r_leaf_dist[i] <= sq_dist(w_query_word, w_leaf_word[i]);
            end
        end else begin
            r_leaf_dist <= r_leaf_dist;
        end
    end

    // Min reduction; strict less-than keeps the lowest index on ties
    always_comb begin
        w_best_dist = r_leaf_dist[0];
        w_best_idx  = {PIDX_W{1'b0}};
`ifdef SECOND_BEST_EN
        w_sec_dist  = {DIST_W{1'b1}};
        w_sec_idx   = {PIDX_W{1'b0}};
`endif
        for (int i = 1; i < LEAF_SIZE; i++) begin
            if (r_leaf_dist[i] < w_best_dist) begin
`ifdef SECOND_BEST_EN
                // Displaced winner becomes the runner-up
                w_sec_dist  = w_best_dist;
                w_sec_idx   = w_best_idx;
`endif
                w_best_dist = r_leaf_dist[i];
                w_best_idx  = PIDX_W'(i);
            end
`ifdef SECOND_BEST_EN
            else if (r_leaf_dist[i] < w_sec_dist) begin
                w_sec_dist = r_leaf_dist[i];
                w_sec_idx  = PIDX_W'(i);
            end else begin
                w_sec_dist = w_sec_dist;
            end
`else
            else begin
                w_best_dist = w_best_dist;
            end
`endif
        end
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {ADDR_WIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_res_qidx <= {ADDR_WIDTH{1'b0}};
            r_res_pidx <= {PIDX_W{1'b0}};
            r_res_dist <= {DIST_W{1'b0}};
`ifdef SECOND_BEST_EN
            r_res_pidx2 <= {PIDX_W{1'b0}};
            r_res_dist2 <= {DIST_W{1'b0}};
`endif
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.fsm_start) begin
                        r_state <= ST_READ;
                        r_cnt   <= {ADDR_WIDTH{1'b0}};
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_state <= ST_SELECT;
                end
                ST_SELECT: begin
                    r_valid    <= 1'b1;
                    r_res_qidx <= r_cnt;
                    r_res_pidx <= w_best_idx;
                    r_res_dist <= w_best_dist;
`ifdef SECOND_BEST_EN
                    r_res_pidx2 <= w_sec_idx;
                    r_res_dist2 <= w_sec_dist;
`endif
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_state <= ST_READ;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy             = r_busy;
    assign bus.fsm_done         = r_done;
    assign bus.result_valid     = r_valid;
    assign bus.result_query_idx = r_res_qidx;
    assign bus.result_patch_idx = r_res_pidx;
    assign bus.result_dist      = r_res_dist;
`ifdef SECOND_BEST_EN
    assign bus.result_patch_idx2 = r_res_pidx2;
    assign bus.result_dist2      = r_res_dist2;
`endif
endmodule

// File: tb/tb_ann_leaf_search_top.sv
// Directed bench for ann_leaf_search_top: memories are loaded hierarchically,
// every scan is recorded and compared against hand-computed expectations.
module tb_ann_leaf_search_top;
    localparam int AW  = 6;
    localparam int PW  = 3;
    localparam int DSW = 26;
    localparam int W   = 55;
    localparam int NL  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ann_leaf_search_if #(.ADDR_WIDTH(AW), .PIDX_WIDTH(PW), .DIST_WIDTH(DSW)) bus_if ();

    ann_leaf_search_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    int n_valid, n_done, done_cyc, first_cyc, busy_at1, busy_at_done;
    logic [AW-1:0]  got_q [NL];
    logic [PW-1:0]  got_p [NL];
    logic [DSW-1:0] got_d [NL];
    logic [PW-1:0]  exp_p [NL];
    logic [DSW-1:0] exp_d [NL];
`ifdef SECOND_BEST_EN
    logic [PW-1:0]  got_p2 [NL];
    logic [DSW-1:0] got_d2 [NL];
`endif

    function automatic logic [W-1:0] pk(input int e0, input int e1, input int e2,
                                        input int e3, input int e4);
        logic [W-1:0] w;
        w = '0;
        w[10:0]  = e0[10:0];
        w[21:11] = e1[10:0];
        w[32:22] = e2[10:0];
        w[43:33] = e3[10:0];
        w[54:44] = e4[10:0];
        return w;
    endfunction

    task automatic write_leaf(input int b, input int a, input logic [W-1:0] w);
        case (b)
            0: dut.leaf_mem_inst.loop_ram_patch_gen[0].ram_patch_inst.mem[a] <= w;
            1: dut.leaf_mem_inst.loop_ram_patch_gen[1].ram_patch_inst.mem[a] <= w;
            2: dut.leaf_mem_inst.loop_ram_patch_gen[2].ram_patch_inst.mem[a] <= w;
            3: dut.leaf_mem_inst.loop_ram_patch_gen[3].ram_patch_inst.mem[a] <= w;
            4: dut.leaf_mem_inst.loop_ram_patch_gen[4].ram_patch_inst.mem[a] <= w;
            5: dut.leaf_mem_inst.loop_ram_patch_gen[5].ram_patch_inst.mem[a] <= w;
            6: dut.leaf_mem_inst.loop_ram_patch_gen[6].ram_patch_inst.mem[a] <= w;
            7: dut.leaf_mem_inst.loop_ram_patch_gen[7].ram_patch_inst.mem[a] <= w;
            default: ;
        endcase
    endtask

    task automatic write_query(input int a, input logic [W-1:0] w);
        dut.query_mem_inst.mem[a] <= w;
    endtask

    task automatic clear_mems();
        for (int a = 0; a < NL; a++) begin
            write_query(a, '0);
            for (int b = 0; b < 8; b++) write_leaf(b, a, '0);
        end
        @(negedge clk);
    endtask

    // Pulse start and record every result for a fixed window; cycle 0 is the
    // start edge. extra_q >= 0 re-pulses start right after that query's result.
    task automatic run_scan(input int extra_q);
        n_valid = 0; n_done = 0; done_cyc = -1; first_cyc = -1;
        busy_at1 = -1; busy_at_done = -1;
        @(negedge clk);
        bus_if.fsm_start = 1'b1;
        @(posedge clk);
        #1 bus_if.fsm_start = 1'b0;
        for (int cyc = 1; cyc <= 230; cyc++) begin
            @(posedge clk);
            #1;
            bus_if.fsm_start = 1'b0;
            if (cyc == 1) busy_at1 = int'(bus_if.busy);
            if (bus_if.result_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (n_valid < NL) begin
                    got_q[n_valid] = bus_if.result_query_idx;
                    got_p[n_valid] = bus_if.result_patch_idx;
                    got_d[n_valid] = bus_if.result_dist;
`ifdef SECOND_BEST_EN
                    got_p2[n_valid] = bus_if.result_patch_idx2;
                    got_d2[n_valid] = bus_if.result_dist2;
`endif
                end
                n_valid++;
                if (extra_q >= 0 && int'(bus_if.result_query_idx) == extra_q)
                    bus_if.fsm_start = 1'b1;
            end
            if (bus_if.fsm_done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = int'(bus_if.busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus_if.fsm_start = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus_if.busy); end
        if (bus_if.fsm_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus_if.fsm_done); end
        if (bus_if.result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus_if.result_valid); end
        if (bus_if.result_query_idx !== 6'd0) begin errors++; $display("FAIL rst_qidx got %0d want 0", bus_if.result_query_idx); end
        if (bus_if.result_patch_idx !== 3'd0) begin errors++; $display("FAIL rst_pidx got %0d want 0", bus_if.result_patch_idx); end
        if (bus_if.result_dist !== 26'd0) begin errors++; $display("FAIL rst_dist got %0d want 0", bus_if.result_dist); end
        bus_if.fsm_start = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks += 2;
        if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL start_in_reset_busy got %b want 0", bus_if.busy); end
        if (bus_if.result_valid !== 1'b0) begin errors++; $display("FAIL start_in_reset_valid got %b want 0", bus_if.result_valid); end
    endtask

    task automatic test_all_zero();
        clear_mems();
        run_scan(-1);
        checks += 7;
        if (n_valid != 64) begin errors++; $display("FAIL zero_nvalid got %0d want 64", n_valid); end
        if (n_done != 1) begin errors++; $display("FAIL zero_ndone got %0d want 1", n_done); end
        if (done_cyc != 193) begin errors++; $display("FAIL zero_done_cyc got %0d want 193", done_cyc); end
        if (first_cyc != 3) begin errors++; $display("FAIL zero_first_valid got %0d want 3", first_cyc); end
        if (busy_at1 != 1) begin errors++; $display("FAIL zero_busy_after_start got %0d want 1", busy_at1); end
        if (busy_at_done != 0) begin errors++; $display("FAIL zero_busy_at_done got %0d want 0", busy_at_done); end
        if (bus_if.result_query_idx !== 6'd63) begin errors++; $display("FAIL zero_hold_qidx got %0d want 63", bus_if.result_query_idx); end
        for (int i = 0; i < NL; i++) begin
            checks += 3;
            if (got_q[i] !== 6'(i)) begin errors++; $display("FAIL zero_qidx[%0d] got %0d want %0d", i, got_q[i], i); end
            if (got_p[i] !== 3'd0) begin errors++; $display("FAIL zero_pidx[%0d] got %0d want 0", i, got_p[i]); end
            if (got_d[i] !== 26'd0) begin errors++; $display("FAIL zero_dist[%0d] got %0d want 0", i, got_d[i]); end
        end
    endtask

    task automatic load_directed();
        clear_mems();
        // q0: exact match in patch 5
        write_query(0, pk(1, 1, 1, 1, 1));
        write_leaf(5, 0, pk(1, 1, 1, 1, 1));
        // q2: patches 1 and 6 tie at distance 1, the rest at 9
        write_query(2, pk(3, 0, 0, 0, 0));
        write_leaf(1, 2, pk(2, 0, 0, 0, 0));
        write_leaf(6, 2, pk(2, 0, 0, 0, 0));
        // q3: extreme magnitudes, patch 7 is farthest
        write_query(3, pk(-1024, -1024, -1024, -1024, -1024));
        write_leaf(7, 3, pk(1023, 1023, 1023, 1023, 1023));
        // q5: mixed signs; patch 4 -> 9, patch 3 -> 14, zero patches -> 12558
        write_query(5, pk(100, -50, 7, 0, -3));
        write_leaf(3, 5, pk(98, -47, 7, 1, -3));
        write_leaf(4, 5, pk(100, -50, 7, 0, 0));
        // q63: last address, last bank
        write_query(63, pk(0, 0, 0, 0, 5));
        write_leaf(7, 63, pk(0, 0, 0, 0, 5));
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            exp_p[i] = 3'd0;
            exp_d[i] = 26'd0;
        end
        exp_p[0] = 3'd5;  exp_d[0] = 26'd0;
        exp_p[2] = 3'd1;  exp_d[2] = 26'd1;
        exp_p[3] = 3'd0;  exp_d[3] = 26'd5242880;
        exp_p[5] = 3'd4;  exp_d[5] = 26'd9;
        exp_p[63] = 3'd7; exp_d[63] = 26'd0;
    endtask

    task automatic test_directed();
        load_directed();
        run_scan(-1);
        checks += 4;
        if (n_valid != 64) begin errors++; $display("FAIL dir_nvalid got %0d want 64", n_valid); end
        if (bus_if.result_query_idx !== 6'd63) begin errors++; $display("FAIL dir_hold_qidx got %0d want 63", bus_if.result_query_idx); end
        if (bus_if.result_patch_idx !== 3'd7) begin errors++; $display("FAIL dir_hold_pidx got %0d want 7", bus_if.result_patch_idx); end
        if (bus_if.result_valid !== 1'b0) begin errors++; $display("FAIL dir_hold_valid got %b want 0", bus_if.result_valid); end
        for (int i = 0; i < NL; i++) begin
            checks += 3;
            if (got_q[i] !== 6'(i)) begin errors++; $display("FAIL dir_qidx[%0d] got %0d want %0d", i, got_q[i], i); end
            if (got_p[i] !== exp_p[i]) begin errors++; $display("FAIL dir_pidx[%0d] got %0d want %0d", i, got_p[i], exp_p[i]); end
            if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL dir_dist[%0d] got %0d want %0d", i, got_d[i], exp_d[i]); end
        end
`ifdef SECOND_BEST_EN
        checks += 10;
        if (got_p2[0] !== 3'd0) begin errors++; $display("FAIL sec_pidx[0] got %0d want 0", got_p2[0]); end
        if (got_d2[0] !== 26'd5) begin errors++; $display("FAIL sec_dist[0] got %0d want 5", got_d2[0]); end
        if (got_p2[2] !== 3'd6) begin errors++; $display("FAIL sec_pidx[2] got %0d want 6", got_p2[2]); end
        if (got_d2[2] !== 26'd1) begin errors++; $display("FAIL sec_dist[2] got %0d want 1", got_d2[2]); end
        if (got_p2[3] !== 3'd1) begin errors++; $display("FAIL sec_pidx[3] got %0d want 1", got_p2[3]); end
        if (got_d2[3] !== 26'd5242880) begin errors++; $display("FAIL sec_dist[3] got %0d want 5242880", got_d2[3]); end
        if (got_p2[5] !== 3'd3) begin errors++; $display("FAIL sec_pidx[5] got %0d want 3", got_p2[5]); end
        if (got_d2[5] !== 26'd14) begin errors++; $display("FAIL sec_dist[5] got %0d want 14", got_d2[5]); end
        if (got_p2[63] !== 3'd0) begin errors++; $display("FAIL sec_pidx[63] got %0d want 0", got_p2[63]); end
        if (got_d2[63] !== 26'd25) begin errors++; $display("FAIL sec_dist[63] got %0d want 25", got_d2[63]); end
`endif
    endtask

    task automatic test_start_ignored();
        run_scan(10);
        checks += 5;
        if (n_valid != 64) begin errors++; $display("FAIL busy_start_nvalid got %0d want 64", n_valid); end
        if (n_done != 1) begin errors++; $display("FAIL busy_start_ndone got %0d want 1", n_done); end
        if (done_cyc != 193) begin errors++; $display("FAIL busy_start_done_cyc got %0d want 193", done_cyc); end
        if (got_q[11] !== 6'd11) begin errors++; $display("FAIL busy_start_qidx11 got %0d want 11", got_q[11]); end
        if (got_q[63] !== 6'd63) begin errors++; $display("FAIL busy_start_qidx63 got %0d want 63", got_q[63]); end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        @(negedge clk);
        bus_if.fsm_start = 1'b1;
        @(posedge clk);
        #1 bus_if.fsm_start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk);
            #1;
            if (bus_if.result_valid && bus_if.result_query_idx == 6'd19) begin
                found = 1'b1;
                break;
            end
        end
        checks += 1;
        if (!found) begin errors++; $display("FAIL midrst_wait_q19 got timeout want result 19"); end
        // Engine is now reading query 20
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks += 6;
        if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus_if.busy); end
        if (bus_if.fsm_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus_if.fsm_done); end
        if (bus_if.result_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus_if.result_valid); end
        if (bus_if.result_query_idx !== 6'd0) begin errors++; $display("FAIL midrst_qidx got %0d want 0", bus_if.result_query_idx); end
        if (bus_if.result_patch_idx !== 3'd0) begin errors++; $display("FAIL midrst_pidx got %0d want 0", bus_if.result_patch_idx); end
        if (bus_if.result_dist !== 26'd0) begin errors++; $display("FAIL midrst_dist got %0d want 0", bus_if.result_dist); end
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(-1);
        checks += 5;
        if (n_valid != 64) begin errors++; $display("FAIL restart_nvalid got %0d want 64", n_valid); end
        if (got_q[0] !== 6'd0) begin errors++; $display("FAIL restart_qidx0 got %0d want 0", got_q[0]); end
        if (got_p[0] !== 3'd5) begin errors++; $display("FAIL restart_pidx0 got %0d want 5", got_p[0]); end
        if (got_d[3] !== 26'd5242880) begin errors++; $display("FAIL restart_dist3 got %0d want 5242880", got_d[3]); end
        if (done_cyc != 193) begin errors++; $display("FAIL restart_done_cyc got %0d want 193", done_cyc); end
    endtask

    initial begin
        bus_if.fsm_start = 1'b0;
        test_reset();
        test_all_zero();
        test_directed();
        test_start_ignored();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
